// File: rtl/byte_serializer.sv
// Parallel-to-serial transmitter for the ANN serial link: a small word FIFO feeding
// an MSB-first shifter that strobes data_ready for every bit it drives on ser_out.
module byte_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        ser_out,
    output logic                        data_ready,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = $clog2(DATA_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [3:0] GAP_LAST = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] shift_reg;
    logic [BIT_W-1:0]  bit_cnt;
    logic [3:0]        gap_cnt;
    logic              push;
    logic              pop;
    logic              shift;
    logic              fifo_empty;

    // A transfer on the input side happens on any edge where in_valid and in_ready are both high.
    assign fifo_empty = (fifo_count == '0);
    assign in_ready   = !reset && (fifo_count < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign busy       = (state != IDLE) || !fifo_empty;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        shift      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt != BIT_LAST) begin
                    shift = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    state_next = GAP;
                end else if (!fifo_empty) begin
                    pop = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            GAP: begin
                // The edge that closes the gap doubles as the IDLE pop edge.
                if (gap_cnt == GAP_LAST) begin
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = SHIFT;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ser_out    <= 1'b0;
            data_ready <= 1'b0;
        end else begin
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : 4'd0;
            if (pop) begin
                shift_reg  <= mem[rd_ptr];
                bit_cnt    <= '0;
                ser_out    <= mem[rd_ptr][DATA_W-1];
                data_ready <= 1'b1;
            end else if (shift) begin
                shift_reg  <= shift_reg << 1;
                bit_cnt    <= bit_cnt + 1'b1;
                ser_out    <= shift_reg[DATA_W-2];
                data_ready <= 1'b1;
            end else begin
                ser_out    <= 1'b0;
                data_ready <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: one instance without gaps and one with GAP_CYCLES=3,
// rebuilding bytes from the serial stream and scoring them against pushed words.
module tb_byte_serializer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] in_ready;
    logic [1:0] ser_out;
    logic [1:0] data_ready;
    logic [1:0] busy;
    logic [2:0] fifo_count [2];

    int         cmp_cnt = 0;
    int         err_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    int         nb [2];
    int         run [2];
    int         last_run [2];
    int         zero_run [2];
    int         last_gap [2];
    int         cnt_model [2];
    int         max_cnt [2];
    int         cnt_err [2];
    int         rdy_err [2];
    int         idle_err [2];
    int         simul_seen;
    logic [7:0] sh [2];
    bit         push_pend [2];

    always #5 clk = ~clk;

    byte_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .ser_out(ser_out[0]), .data_ready(data_ready[0]),
        .busy(busy[0]), .fifo_count(fifo_count[0])
    );

    byte_serializer #(.DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(3)) dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .ser_out(ser_out[1]), .data_ready(data_ready[1]),
        .busy(busy[1]), .fifo_count(fifo_count[1])
    );

    // Deserializer model plus occupancy model, sampled on the falling edge.
    task automatic sample();
        bit popped;
        int prev;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                nb[i] = 0; run[i] = 0; cnt_model[i] = 0; sh[i] = 8'h00;
            end else begin
                if (in_ready[i] !== (fifo_count[i] < 3'd4)) rdy_err[i]++;
                popped = data_ready[i] && (nb[i] == 0);
                prev = cnt_model[i];
                cnt_model[i] = cnt_model[i] + int'(push_pend[i]) - int'(popped);
                if (int'(fifo_count[i]) != cnt_model[i]) cnt_err[i]++;
                if (cnt_model[i] > max_cnt[i]) max_cnt[i] = cnt_model[i];
                if (push_pend[i] && popped && prev == 2 && fifo_count[i] == 3'd2) simul_seen++;
                if (data_ready[i]) begin
                    if (run[i] == 0) last_gap[i] = zero_run[i];
                    run[i]++;
                    zero_run[i] = 0;
                    sh[i] = {sh[i][6:0], ser_out[i]};
                    nb[i]++;
                    if (nb[i] == 8) begin
                        got_q.push_back(sh[i]);
                        nb[i] = 0;
                    end
                end else begin
                    if (run[i] != 0) last_run[i] = run[i];
                    run[i] = 0;
                    zero_run[i]++;
                    if (ser_out[i] !== 1'b0) idle_err[i]++;
                end
            end
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [7:0] d);
        #1;
        in_valid = 2'b00;
        in_data = d;
        push_pend[0] = 1'b0;
        push_pend[1] = 1'b0;
        in_valid[sel] = v;
        push_pend[sel] = v && in_ready[sel] && !reset;
        if (push_pend[sel]) exp_q.push_back(d);
    endtask

    task automatic step(input int sel, input logic v, input logic [7:0] d);
        sample();
        drive(sel, v, d);
    endtask

    task automatic push_word(input int sel, input logic [7:0] d, output bit to);
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(sel, 1'b1, d);
            if (push_pend[sel]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int sel, output bit to);
        to = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(sel, 1'b0, 8'h00);
            if (!busy[sel] && !data_ready[sel]) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic clear_stats();
        exp_q.delete();
        got_q.delete();
        simul_seen = 0;
        for (int i = 0; i < 2; i++) begin
            max_cnt[i] = 0; cnt_err[i] = 0; rdy_err[i] = 0; idle_err[i] = 0;
            last_run[i] = 0; last_gap[i] = 0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(0, 1'b1, 8'h99);
        step(0, 1'b1, 8'h99);
        for (int i = 0; i < 2; i++) begin
            cmp_cnt++;
            if ({ser_out[i], data_ready[i], busy[i], in_ready[i]} !== 4'b0000 || fifo_count[i] !== 3'd0) begin
                err_cnt++;
                $display("FAIL reset_outputs dut%0d: so/dr/busy/rdy=%b%b%b%b count=%0d, required 0000 count=0",
                         i, ser_out[i], data_ready[i], busy[i], in_ready[i], fifo_count[i]);
            end
        end
        reset = 1'b0;
        in_valid = 2'b00;
        #1;
        cmp_cnt++;
        if (in_ready !== 2'b11) begin
            err_cnt++;
            $display("FAIL reset_release_ready: got %b, required 11", in_ready);
        end
        clear_stats();
    endtask

    task automatic test_single();
        logic [7:0] bits;
        bit to;
        clear_stats();
        push_word(0, 8'hA5, to);
        step(0, 1'b0, 8'h00);
        cmp_cnt++;
        if (to || data_ready[0] !== 1'b0 || fifo_count[0] !== 3'd1) begin
            err_cnt++;
            $display("FAIL single_push_edge: to=%0d dr=%b count=%0d, required dr=0 count=1", to, data_ready[0], fifo_count[0]);
        end
        for (int i = 0; i < 8; i++) begin
            step(0, 1'b0, 8'h00);
            bits[7-i] = ser_out[0];
            cmp_cnt++;
            if (data_ready[0] !== 1'b1) begin
                err_cnt++;
                $display("FAIL single_strobe bit%0d: dr=%b, required 1", i, data_ready[0]);
            end
        end
        cmp_cnt++;
        if (bits !== 8'hA5) begin
            err_cnt++;
            $display("FAIL single_bits: got %h, required a5", bits);
        end
        step(0, 1'b0, 8'h00);
        cmp_cnt++;
        if (data_ready[0] !== 1'b0 || last_run[0] != 8 || idle_err[0] != 0) begin
            err_cnt++;
            $display("FAIL single_end: dr=%b run=%0d idle_err=%0d, required dr=0 run=8 idle_err=0", data_ready[0], last_run[0], idle_err[0]);
        end
        cmp_cnt++;
        if (got_q.size() != 1) begin
            err_cnt++;
            $display("FAIL single_count: got %0d words, required 1", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL single_data: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit to;
        bit any_to;
        logic [7:0] words [3] = '{8'h3C, 8'hFF, 8'h01};
        clear_stats();
        any_to = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push_word(0, words[i], to);
            any_to |= to;
        end
        wait_idle(0, to);
        any_to |= to;
        cmp_cnt++;
        if (any_to || last_run[0] != 24 || cnt_err[0] != 0 || idle_err[0] != 0) begin
            err_cnt++;
            $display("FAIL b2b_stream: to=%0d run=%0d cnt_err=%0d idle_err=%0d, required run=24 and no errors",
                     any_to, last_run[0], cnt_err[0], idle_err[0]);
        end
        cmp_cnt++;
        if (got_q.size() != 3) begin
            err_cnt++;
            $display("FAIL b2b_count: got %0d words, required 3", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL b2b_data: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_full();
        bit to;
        bit any_to;
        clear_stats();
        any_to = 1'b0;
        for (int w = 8'h10; w <= 8'h15; w++) begin
            push_word(0, 8'(w), to);
            any_to |= to;
        end
        wait_idle(0, to);
        any_to |= to;
        cmp_cnt++;
        if (any_to || max_cnt[0] != 4 || rdy_err[0] != 0 || cnt_err[0] != 0) begin
            err_cnt++;
            $display("FAIL full_fifo: to=%0d max_count=%0d rdy_err=%0d cnt_err=%0d, required max_count=4 and no errors",
                     any_to, max_cnt[0], rdy_err[0], cnt_err[0]);
        end
        cmp_cnt++;
        if (got_q.size() != 6) begin
            err_cnt++;
            $display("FAIL full_count: got %0d words, required 6", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL full_data: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_simul_push_pop();
        bit to;
        bit any_to;
        clear_stats();
        any_to = 1'b0;
        for (int w = 8'h20; w <= 8'h22; w++) begin
            push_word(0, 8'(w), to);
            any_to |= to;
        end
        // Line the fourth push up with the pop edge that follows the first word's LSB.
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (data_ready[0] && nb[0] == 0 && fifo_count[0] == 3'd2) begin
                to = 1'b0;
                break;
            end
            drive(0, 1'b0, 8'h00);
        end
        any_to |= to;
        drive(0, 1'b1, 8'h23);
        for (int w = 8'h24; w <= 8'h29; w++) begin
            repeat ($urandom_range(0, 3)) step(0, 1'b0, 8'h00);
            push_word(0, 8'(w), to);
            any_to |= to;
        end
        wait_idle(0, to);
        any_to |= to;
        cmp_cnt++;
        if (any_to || simul_seen == 0 || cnt_err[0] != 0 || rdy_err[0] != 0) begin
            err_cnt++;
            $display("FAIL simul_push_pop: to=%0d simul=%0d cnt_err=%0d rdy_err=%0d, required simul>0 and no errors",
                     any_to, simul_seen, cnt_err[0], rdy_err[0]);
        end
        cmp_cnt++;
        if (got_q.size() != 10) begin
            err_cnt++;
            $display("FAIL simul_count: got %0d words, required 10", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL simul_data: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_gap();
        bit to;
        bit any_to;
        clear_stats();
        push_word(1, 8'h81, to);
        any_to = to;
        push_word(1, 8'h7E, to);
        any_to |= to;
        wait_idle(1, to);
        any_to |= to;
        cmp_cnt++;
        if (any_to || last_gap[1] != 3 || last_run[1] != 8 || idle_err[1] != 0 || cnt_err[1] != 0) begin
            err_cnt++;
            $display("FAIL gap_timing: to=%0d gap=%0d run=%0d idle_err=%0d cnt_err=%0d, required gap=3 run=8 and no errors",
                     any_to, last_gap[1], last_run[1], idle_err[1], cnt_err[1]);
        end
        cmp_cnt++;
        if (got_q.size() != 2) begin
            err_cnt++;
            $display("FAIL gap_count: got %0d words, required 2", got_q.size());
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL gap_data: got %h, required %h", g, e);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        bit to;
        bit any_to;
        clear_stats();
        push_word(0, 8'hC3, to);
        any_to = to;
        push_word(0, 8'h11, to);
        any_to |= to;
        push_word(0, 8'h22, to);
        any_to |= to;
        to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            sample();
            if (nb[0] == 4) begin
                to = 1'b0;
                break;
            end
            drive(0, 1'b0, 8'h00);
        end
        any_to |= to;
        in_valid = 2'b00;
        push_pend[0] = 1'b0;
        push_pend[1] = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        cmp_cnt++;
        if (any_to || data_ready[0] !== 1'b0 || ser_out[0] !== 1'b0 || busy[0] !== 1'b0 ||
            in_ready[0] !== 1'b0 || fifo_count[0] !== 3'd0) begin
            err_cnt++;
            $display("FAIL reset_mid_word: to=%0d dr=%b so=%b busy=%b rdy=%b count=%0d, required all zero",
                     any_to, data_ready[0], ser_out[0], busy[0], in_ready[0], fifo_count[0]);
        end
        exp_q.delete();
        got_q.delete();
        step(0, 1'b0, 8'h00);
        step(0, 1'b0, 8'h00);
        reset = 1'b0;
        clear_stats();
        push_word(0, 8'h5A, to);
        any_to = to;
        wait_idle(0, to);
        any_to |= to;
        cmp_cnt++;
        if (any_to || got_q.size() != 1 || cnt_err[0] != 0) begin
            err_cnt++;
            $display("FAIL reset_recover: to=%0d words=%0d cnt_err=%0d, required 1 word and no errors",
                     any_to, got_q.size(), cnt_err[0]);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] g = got_q.pop_front();
            logic [7:0] e = exp_q.pop_front();
            cmp_cnt++;
            if (g !== e) begin
                err_cnt++;
                $display("FAIL reset_recover_data: got %h, required %h", g, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_simul_push_pop();
        test_gap();
        test_reset_mid_word();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
